// File: rtl/pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_control_unit (with cpu_types_pkg encodings)
// Purpose  : Decodes the IF/ID instruction into a control word and carries it
//            through ID/EX, EX/MEM and MEM/WB control registers. Handles
//            memory stall, branch/jump flush, load-use hazard detection and
//            a sticky halt.
// Ports    : CLK, nRST                   clock, async active-low reset
//            instr_i, instr_valid_i      IF/ID instruction and its valid flag
//            stall_i, flush_i            freeze all stages / bubble into ID/EX
//            id_stall_o, illegal_o       combinational ID hazard / bad opcode
//            ex_*_o                      ID/EX controls for the EX stage
//            mem_wr_o, mem_rd_o          EX/MEM data-memory requests
//            wb_regwr_o, wb_memtoreg_o,
//            wb_wsel_o                   MEM/WB write-back controls
//            halt_o                      sticky HALT-retired flag
// Revision : 1.0 - initial release
// ============================================================================

package cpu_types_pkg;

    typedef enum logic [5:0] {
        RTYPE = 6'h00, J     = 6'h02, JAL   = 6'h03, BEQ   = 6'h04,
        BNE   = 6'h05, ADDI  = 6'h08, ADDIU = 6'h09, SLTI  = 6'h0A,
        SLTIU = 6'h0B, ANDI  = 6'h0C, ORI   = 6'h0D, XORI  = 6'h0E,
        LUI   = 6'h0F, LW    = 6'h23, LBU   = 6'h24, LHU   = 6'h25,
        SB    = 6'h28, SH    = 6'h29, SW    = 6'h2B, LL    = 6'h30,
        SC    = 6'h38, HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        SLL  = 6'h00, SRL  = 6'h02, JR   = 6'h08, ADD  = 6'h20,
        ADDU = 6'h21, SUB  = 6'h22, SUBU = 6'h23, AND  = 6'h24,
        OR   = 6'h25, XOR  = 6'h26, NOR  = 6'h27, SLT  = 6'h2A,
        SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
        ALU_AND  = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
        ALU_SLT  = 4'd8, ALU_SLTU = 4'd9
    } aluop_t;

endpackage

module pipeline_control_unit
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [WORD_W-1:0]     instr_i,
    input  logic                  instr_valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic                  id_stall_o,
    output logic                  illegal_o,
    output aluop_t                ex_aluctr_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_extop_o,
    output logic                  ex_lui_o,
    output logic                  ex_beq_o,
    output logic                  ex_bne_o,
    output logic                  ex_j_o,
    output logic                  ex_jal_o,
    output logic                  ex_jr_o,
    output logic                  mem_wr_o,
    output logic                  mem_rd_o,
    output logic                  wb_regwr_o,
    output logic                  wb_memtoreg_o,
    output logic [REG_ADDR_W-1:0] wb_wsel_o,
    output logic                  halt_o
);

    typedef struct packed {
        logic                  alusrc;
        logic                  extop;
        logic                  lui;
        logic                  beq;
        logic                  bne;
        logic                  j;
        logic                  jal;
        logic                  jr;
        logic                  memwr;
        logic                  memrd;
        logic                  regwr;
        logic                  memtoreg;
        logic                  halt;
        aluop_t                aluctr;
        logic [REG_ADDR_W-1:0] wsel;
    } ctrl_t;

    localparam ctrl_t c_bubble = '{
        alusrc: 1'b0, extop: 1'b1, lui: 1'b0, beq: 1'b0, bne: 1'b0,
        j: 1'b0, jal: 1'b0, jr: 1'b0, memwr: 1'b0, memrd: 1'b0,
        regwr: 1'b0, memtoreg: 1'b0, halt: 1'b0, aluctr: ALU_SLL, wsel: '0
    };

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    opcode_t               w_opcode;
    funct_t                w_funct;
    logic [REG_ADDR_W-1:0] w_rs, w_rt, w_rd;
    logic                  w_dec_valid;
    logic                  w_legal;
    logic                  w_regdst;
    ctrl_t                 w_raw;
    ctrl_t                 w_id_word;
    logic                  w_use_rs, w_use_rt;
    logic                  w_unused_instr;

    ctrl_t                 r_idex;
    logic                  r_exmem_memwr, r_exmem_memrd, r_exmem_regwr;
    logic                  r_exmem_memtoreg, r_exmem_halt;
    logic [REG_ADDR_W-1:0] r_exmem_wsel;
    logic                  r_memwb_regwr, r_memwb_memtoreg, r_memwb_halt;
    logic [REG_ADDR_W-1:0] r_memwb_wsel;
    logic                  r_halt;

    assign w_opcode = opcode_t'(instr_i[31:26]);
    assign w_funct  = funct_t'(instr_i[5:0]);
    assign w_rs     = REG_ADDR_W'(instr_i[25:21]);
    assign w_rt     = REG_ADDR_W'(instr_i[20:16]);
    assign w_rd     = REG_ADDR_W'(instr_i[15:11]);

    // Immediate, shamt and jump-target bits belong to the datapath.
    assign w_unused_instr = ^instr_i;

    // Once halted, ID behaves as if nothing valid is ever presented.
    assign w_dec_valid = instr_valid_i & ~r_halt;

    always_comb begin
        w_raw    = c_bubble;
        w_regdst = 1'b0;
        w_legal  = 1'b1;
        case (w_opcode)
            RTYPE: begin
                w_regdst    = 1'b1;
                w_raw.regwr = 1'b1;
                case (w_funct)
                    SLL:       w_raw.aluctr = ALU_SLL;
                    SRL:       w_raw.aluctr = ALU_SRL;
                    ADD, ADDU: w_raw.aluctr = ALU_ADD;
                    SUB, SUBU: w_raw.aluctr = ALU_SUB;
                    AND:       w_raw.aluctr = ALU_AND;
                    OR:        w_raw.aluctr = ALU_OR;
                    XOR:       w_raw.aluctr = ALU_XOR;
                    NOR:       w_raw.aluctr = ALU_NOR;
                    SLT:       w_raw.aluctr = ALU_SLT;
                    SLTU:      w_raw.aluctr = ALU_SLTU;
                    JR: begin
                        w_raw.jr     = 1'b1;
                        w_raw.regwr  = 1'b0;
                        w_raw.aluctr = ALU_ADD;
                    end
                    default:   w_legal = 1'b0;
                endcase
            end
            ADDI, ADDIU: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.aluctr = ALU_ADD;
            end
            SLTI: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.aluctr = ALU_SLT;
            end
            SLTIU: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.aluctr = ALU_SLTU;
            end
            ANDI: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.extop = 1'b0;
                w_raw.aluctr = ALU_AND;
            end
            ORI: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.extop = 1'b0;
                w_raw.aluctr = ALU_OR;
            end
            XORI: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.extop = 1'b0;
                w_raw.aluctr = ALU_XOR;
            end
            LUI: begin
                w_raw.alusrc = 1'b1; w_raw.regwr = 1'b1; w_raw.lui = 1'b1;
            end
            LW: begin
                w_raw.alusrc = 1'b1; w_raw.memtoreg = 1'b1; w_raw.regwr = 1'b1;
                w_raw.memrd  = 1'b1; w_raw.aluctr   = ALU_ADD;
            end
            SW: begin
                w_raw.alusrc = 1'b1; w_raw.memwr = 1'b1; w_raw.aluctr = ALU_ADD;
            end
            BEQ: begin
                w_raw.beq = 1'b1; w_raw.aluctr = ALU_SUB;
            end
            BNE: begin
                w_raw.bne = 1'b1; w_raw.aluctr = ALU_SUB;
            end
            J:       w_raw.j = 1'b1;
            JAL: begin
                w_raw.jal = 1'b1; w_raw.regwr = 1'b1;
            end
            HALT:    w_raw.halt = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // Qualified ID word; a word that never writes the register file carries
    // wsel=0 so the hazard compare cannot match on a stale field.
    always_comb begin
        w_id_word = c_bubble;
        if (w_dec_valid && w_legal) begin
            w_id_word = w_raw;
            if (!w_raw.regwr)
                w_id_word.wsel = '0;
            else if (w_regdst)
                w_id_word.wsel = w_rd;
            else if (w_raw.jal)
                w_id_word.wsel = REG_ADDR_W'(31);
            else
                w_id_word.wsel = w_rt;
        end
    end

    assign illegal_o = w_dec_valid & ~w_legal;

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
    assign w_use_rs = w_dec_valid && !(w_opcode inside {J, JAL, LUI, HALT});
    assign w_use_rt = w_dec_valid &&  (w_opcode inside {RTYPE, BEQ, BNE, SW});

    generate
        if (HAZARD_EN) begin : g_hazard
            assign id_stall_o = r_idex.memtoreg && (r_idex.wsel != '0) &&
                                ((w_use_rs && (r_idex.wsel == w_rs)) ||
                                 (w_use_rt && (r_idex.wsel == w_rt)));
        end else begin : g_no_hazard
            logic unused_hazard;
            assign unused_hazard = ^{w_use_rs, w_use_rt, w_rs};
            assign id_stall_o    = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_idex           <= c_bubble;
            r_exmem_memwr    <= 1'b0;
            r_exmem_memrd    <= 1'b0;
            r_exmem_regwr    <= 1'b0;
            r_exmem_memtoreg <= 1'b0;
            r_exmem_halt     <= 1'b0;
            r_exmem_wsel     <= '0;
            r_memwb_regwr    <= 1'b0;
            r_memwb_memtoreg <= 1'b0;
            r_memwb_halt     <= 1'b0;
            r_memwb_wsel     <= '0;
            r_halt           <= 1'b0;
        end else if (!stall_i) begin
            // Flush and load-use both insert a bubble; the stalled ID
            // instruction is simply re-decoded next cycle.
            if (flush_i || id_stall_o)
                r_idex <= c_bubble;
            else
                r_idex <= w_id_word;
            r_exmem_memwr    <= r_idex.memwr;
            r_exmem_memrd    <= r_idex.memrd;
            r_exmem_regwr    <= r_idex.regwr;
            r_exmem_memtoreg <= r_idex.memtoreg;
            r_exmem_halt     <= r_idex.halt;
            r_exmem_wsel     <= r_idex.wsel;
            r_memwb_regwr    <= r_exmem_regwr;
            r_memwb_memtoreg <= r_exmem_memtoreg;
            r_memwb_halt     <= r_exmem_halt;
            r_memwb_wsel     <= r_exmem_wsel;
            if (r_memwb_halt)
                r_halt <= 1'b1;
        end
    end

    assign ex_aluctr_o   = r_idex.aluctr;
    assign ex_alusrc_o   = r_idex.alusrc;
    assign ex_extop_o    = r_idex.extop;
    assign ex_lui_o      = r_idex.lui;
    assign ex_beq_o      = r_idex.beq;
    assign ex_bne_o      = r_idex.bne;
    assign ex_j_o        = r_idex.j;
    assign ex_jal_o      = r_idex.jal;
    assign ex_jr_o       = r_idex.jr;
    assign mem_wr_o      = r_exmem_memwr;
    assign mem_rd_o      = r_exmem_memrd;
    assign wb_regwr_o    = r_memwb_regwr;
    assign wb_memtoreg_o = r_memwb_memtoreg;
    assign wb_wsel_o     = r_memwb_wsel;
    assign halt_o        = r_halt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_control_unit
// Purpose  : Directed self-checking bench for pipeline_control_unit. A second
//            instance with HAZARD_EN=0 shares the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_control_unit;

    logic        CLK;
    logic        nRST;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        stall_i;
    logic        flush_i;

    logic                  id_stall_o, illegal_o;
    cpu_types_pkg::aluop_t ex_aluctr_o;
    logic ex_alusrc_o, ex_extop_o, ex_lui_o, ex_beq_o, ex_bne_o;
    logic ex_j_o, ex_jal_o, ex_jr_o, mem_wr_o, mem_rd_o;
    logic wb_regwr_o, wb_memtoreg_o, halt_o;
    logic [4:0] wb_wsel_o;

    logic                  nh_id_stall_o, nh_illegal_o;
    cpu_types_pkg::aluop_t nh_ex_aluctr_o;
    logic nh_ex_alusrc_o, nh_ex_extop_o, nh_ex_lui_o, nh_ex_beq_o, nh_ex_bne_o;
    logic nh_ex_j_o, nh_ex_jal_o, nh_ex_jr_o, nh_mem_wr_o, nh_mem_rd_o;
    logic nh_wb_regwr_o, nh_wb_memtoreg_o, nh_halt_o;
    logic [4:0] nh_wb_wsel_o;

    int n_checks;
    int n_errors;

    pipeline_control_unit #(.WORD_W(32), .REG_ADDR_W(5), .HAZARD_EN(1'b1)) dut (
        .CLK(CLK), .nRST(nRST), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .id_stall_o(id_stall_o),
        .illegal_o(illegal_o), .ex_aluctr_o(ex_aluctr_o), .ex_alusrc_o(ex_alusrc_o),
        .ex_extop_o(ex_extop_o), .ex_lui_o(ex_lui_o), .ex_beq_o(ex_beq_o),
        .ex_bne_o(ex_bne_o), .ex_j_o(ex_j_o), .ex_jal_o(ex_jal_o), .ex_jr_o(ex_jr_o),
        .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .wb_regwr_o(wb_regwr_o),
        .wb_memtoreg_o(wb_memtoreg_o), .wb_wsel_o(wb_wsel_o), .halt_o(halt_o)
    );

    pipeline_control_unit #(.WORD_W(32), .REG_ADDR_W(5), .HAZARD_EN(1'b0)) dut_nh (
        .CLK(CLK), .nRST(nRST), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
        .stall_i(stall_i), .flush_i(flush_i), .id_stall_o(nh_id_stall_o),
        .illegal_o(nh_illegal_o), .ex_aluctr_o(nh_ex_aluctr_o),
        .ex_alusrc_o(nh_ex_alusrc_o), .ex_extop_o(nh_ex_extop_o),
        .ex_lui_o(nh_ex_lui_o), .ex_beq_o(nh_ex_beq_o), .ex_bne_o(nh_ex_bne_o),
        .ex_j_o(nh_ex_j_o), .ex_jal_o(nh_ex_jal_o), .ex_jr_o(nh_ex_jr_o),
        .mem_wr_o(nh_mem_wr_o), .mem_rd_o(nh_mem_rd_o), .wb_regwr_o(nh_wb_regwr_o),
        .wb_memtoreg_o(nh_wb_memtoreg_o), .wb_wsel_o(nh_wb_wsel_o),
        .halt_o(nh_halt_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        instr_i       = 32'h0;
        instr_valid_i = 1'b0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        nRST          = 1'b1;
        #1 nRST = 1'b0;
        #2;
        check("rst_extop",   ex_extop_o,    1);
        check("rst_aluctr",  ex_aluctr_o,   0);
        check("rst_alusrc",  ex_alusrc_o,   0);
        check("rst_memwr",   mem_wr_o,      0);
        check("rst_memrd",   mem_rd_o,      0);
        check("rst_regwr",   wb_regwr_o,    0);
        check("rst_wsel",    wb_wsel_o,     0);
        check("rst_halt",    halt_o,        0);
        check("rst_idstall", id_stall_o,    0);
        tick();
        nRST = 1'b1;

        // ADDI $t0,$zero,5
        instr_i = 32'h20080005; instr_valid_i = 1'b1;
        tick();
        check("addi_alusrc", ex_alusrc_o, 1);
        check("addi_aluctr", ex_aluctr_o, 2);
        check("addi_extop",  ex_extop_o,  1);
        check("addi_wb_early", wb_regwr_o, 0);
        instr_valid_i = 1'b0;
        tick();
        tick();
        check("addi_wb_regwr", wb_regwr_o, 1);
        check("addi_wb_wsel",  wb_wsel_o,  8);
        tick();

        // LW $t0,0($s0) then ADD $t1,$t0,$t2
        instr_i = 32'h8E080000; instr_valid_i = 1'b1;
        tick();
        instr_i = 32'h010A4820;
        #1;
        check("lu_stall",    id_stall_o,    1);
        check("lu_nh_stall", nh_id_stall_o, 0);
        tick();
        check("lu_bubble_aluctr", ex_aluctr_o,    0);
        check("lu_nh_add_ex",     nh_ex_aluctr_o, 2);
        check("lu_lw_memrd",      mem_rd_o,       1);
        check("lu_stall_once",    id_stall_o,     0);
        tick();
        check("lu_add_late",     ex_aluctr_o,   2);
        check("lu_lw_memtoreg",  wb_memtoreg_o, 1);
        check("lu_lw_wsel",      wb_wsel_o,     8);
        instr_valid_i = 1'b0;
        tick();
        tick();
        check("lu_add_wsel",     wb_wsel_o,     9);
        check("lu_add_regwr",    wb_regwr_o,    1);
        check("lu_add_memtoreg", wb_memtoreg_o, 0);

        // JAL then JR $ra
        instr_i = 32'h0C000010; instr_valid_i = 1'b1;
        tick();
        check("jal_ex", ex_jal_o, 1);
        check("jal_j",  ex_j_o,   0);
        instr_valid_i = 1'b0;
        tick();
        tick();
        check("jal_wsel",  wb_wsel_o,  31);
        check("jal_regwr", wb_regwr_o, 1);
        instr_i = 32'h03E00008; instr_valid_i = 1'b1;
        tick();
        check("jr_ex", ex_jr_o, 1);
        instr_valid_i = 1'b0;
        tick();
        tick();
        check("jr_regwr", wb_regwr_o, 0);
        check("jr_wsel",  wb_wsel_o,  0);

        // SW held in EX/MEM by a 3-cycle memory stall
        instr_i = 32'hAE090004; instr_valid_i = 1'b1;
        tick();
        check("sw_ex_alusrc", ex_alusrc_o, 1);
        instr_valid_i = 1'b0;
        tick();
        check("sw_memwr", mem_wr_o, 1);
        stall_i = 1'b1; instr_i = 32'h20080005; instr_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sw_hold_memwr", mem_wr_o,    1);
            check("sw_hold_ex",    ex_alusrc_o, 0);
        end
        stall_i = 1'b0; instr_valid_i = 1'b0;
        tick();
        check("sw_release_memwr", mem_wr_o, 0);
        tick();

        // Flush coinciding with a load-use hazard
        instr_i = 32'h8E080000; instr_valid_i = 1'b1;
        tick();
        instr_i = 32'h010A4820; flush_i = 1'b1;
        #1;
        check("fl_stall", id_stall_o, 1);
        tick();
        flush_i = 1'b0;
        check("fl_bubble_aluctr", ex_aluctr_o, 0);
        check("fl_lw_memrd",      mem_rd_o,    1);
        instr_i = 32'h350A00FF;
        #1;
        check("fl_nostall", id_stall_o, 0);
        tick();
        check("fl_ori_aluctr", ex_aluctr_o, 5);
        check("fl_ori_extop",  ex_extop_o,  0);
        check("fl_ori_alusrc", ex_alusrc_o, 1);
        instr_valid_i = 1'b0;
        tick();

        // Illegal opcode / funct
        instr_i = 32'hF8000000; instr_valid_i = 1'b1;
        #1;
        check("ill_opcode", illegal_o, 1);
        tick();
        check("ill_bubble_extop",  ex_extop_o,  1);
        check("ill_bubble_alusrc", ex_alusrc_o, 0);
        instr_i = 32'h0000003F;
        #1;
        check("ill_funct", illegal_o, 1);
        instr_i = 32'h010A4820;
        #1;
        check("ill_legal", illegal_o, 0);
        instr_i = 32'hF8000000; instr_valid_i = 1'b0;
        #1;
        check("ill_invalid", illegal_o, 0);
        tick();

        // HALT and sticky halt
        instr_i = 32'hFC000000; instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        check("halt_e1", halt_o, 0);
        tick();
        check("halt_e2", halt_o, 0);
        tick();
        check("halt_e3", halt_o, 0);
        tick();
        check("halt_rise", halt_o, 1);
        instr_i = 32'h20080005; instr_valid_i = 1'b1;
        tick();
        check("halt_ex_alusrc", ex_alusrc_o, 0);
        tick();
        tick();
        check("halt_wb_regwr", wb_regwr_o, 0);
        check("halt_sticky",   halt_o,     1);
        instr_valid_i = 1'b0;

        // Asynchronous reset mid-operation
        #2 nRST = 1'b0;
        #1;
        check("rst2_halt",  halt_o,     0);
        check("rst2_extop", ex_extop_o, 1);
        #1 nRST = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
